alu_ctrl_pipe: RTL

Registered, parametrised ALU control stage for the pipelined MIPS datapath, sitting between ID and EX. Decodes `ALUOp_i`/`funct_i` into an ALU operation code plus jr, shift-amount and illegal flags, holds them in a valid/stall output register, and sequences multi-cycle MULT/DIV through a countdown FSM that back-pressures the decoder. Extends the single-cycle ALU controller with 3-bit ALUOp immediates (slti/ori/andi/lui/bne), shifts, mult/div, flush and handshaking.

---
 rtl/alu_ctrl_pkg.sv | 50 +++++
 rtl/alu_ctrl_decode.sv | 67 ++++++
 rtl/alu_ctrl_pipe.sv | 111 +++++++++++
 3 files changed

// File: rtl/alu_ctrl_pkg.sv
// ALU control shared definitions: ALUOp, funct and ALU codes,
// FSM states and the decoded-control bundle.
package alu_ctrl_pkg;

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_RTYPE = 3'b010;
  localparam logic [2:0] OP_SLT   = 3'b011;
  localparam logic [2:0] OP_OR    = 3'b100;
  localparam logic [2:0] OP_AND   = 3'b101;
  localparam logic [2:0] OP_LUI   = 3'b110;
  localparam logic [2:0] OP_BNE   = 3'b111;

  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [5:0] FN_MULT = 6'b011000;
  localparam logic [5:0] FN_DIV  = 6'b011010;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLL  = 4'b1000;
  localparam logic [3:0] ALU_SRL  = 4'b1001;
  localparam logic [3:0] ALU_MULT = 4'b1010;
  localparam logic [3:0] ALU_DIV  = 4'b1011;
  localparam logic [3:0] ALU_NOR  = 4'b1100;
  localparam logic [3:0] ALU_LUI  = 4'b1101;

  typedef enum logic {
    S_IDLE,
    S_MD_BUSY
  } state_e;

  typedef struct packed {
    logic [3:0] code;
    logic       jr;
    logic       shamt;
    logic       illegal;
  } alu_dec_t;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational ALUOp/funct decoder producing the ALU control
// bundle and a flag marking multi-cycle MULT/DIV.
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
#(
  parameter int OP_W    = 3,
  parameter int FUNCT_W = 6
) (
  input  logic [OP_W-1:0]    i_op,
  input  logic [FUNCT_W-1:0] i_funct,
  output alu_dec_t           o_dec,
  output logic               o_is_md
);

  logic [2:0] w_op;
  logic [5:0] w_fn;
  alu_dec_t   w_rdec;
  logic       w_rmd;

  assign w_op = 3'(i_op);
  assign w_fn = 6'(i_funct);

  // Unknown R-type funct falls back to ADD and flags illegal.
  always_comb begin
    w_rdec = '{ALU_ADD, 1'b0, 1'b0, 1'b1};
    w_rmd  = 1'b0;
    unique case (1'b1)
      (w_fn == FN_ADD): w_rdec = '{ALU_ADD, 1'b0, 1'b0, 1'b0};
      (w_fn == FN_SUB): w_rdec = '{ALU_SUB, 1'b0, 1'b0, 1'b0};
      (w_fn == FN_AND): w_rdec = '{ALU_AND, 1'b0, 1'b0, 1'b0};
      (w_fn == FN_OR):  w_rdec = '{ALU_OR,  1'b0, 1'b0, 1'b0};
      (w_fn == FN_NOR): w_rdec = '{ALU_NOR, 1'b0, 1'b0, 1'b0};
      (w_fn == FN_SLT): w_rdec = '{ALU_SLT, 1'b0, 1'b0, 1'b0};
      (w_fn == FN_SLL): w_rdec = '{ALU_SLL, 1'b0, 1'b1, 1'b0};
      (w_fn == FN_SRL): w_rdec = '{ALU_SRL, 1'b0, 1'b1, 1'b0};
      (w_fn == FN_JR):  w_rdec = '{ALU_ADD, 1'b1, 1'b0, 1'b0};
      (w_fn == FN_MULT): begin
        w_rdec = '{ALU_MULT, 1'b0, 1'b0, 1'b0};
        w_rmd  = 1'b1;
      end
      (w_fn == FN_DIV): begin
        w_rdec = '{ALU_DIV, 1'b0, 1'b0, 1'b0};
        w_rmd  = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    o_dec   = '{ALU_ADD, 1'b0, 1'b0, 1'b0};
    o_is_md = 1'b0;
    unique case (1'b1)
      (w_op == OP_RTYPE): begin
        o_dec   = w_rdec;
        o_is_md = w_rmd;
      end
      (w_op == OP_SUB): o_dec.code = ALU_SUB;
      (w_op == OP_BNE): o_dec.code = ALU_SUB;
      (w_op == OP_SLT): o_dec.code = ALU_SLT;
      (w_op == OP_OR):  o_dec.code = ALU_OR;
      (w_op == OP_AND): o_dec.code = ALU_AND;
      (w_op == OP_LUI): o_dec.code = ALU_LUI;
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_ctrl_pipe.sv
// Registered ALU control stage between ID and EX with valid/stall
// handshake and a countdown FSM covering multi-cycle MULT/DIV.
module alu_ctrl_pipe
  import alu_ctrl_pkg::*;
#(
  parameter int FUNCT_W   = 6,
  parameter int OP_W      = 3,
  parameter int CTRL_W    = 4,
  parameter int MD_CYCLES = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               valid_i,
  input  logic [OP_W-1:0]    ALUOp_i,
  input  logic [FUNCT_W-1:0] funct_i,
  input  logic               stall_i,
  input  logic               flush_i,
  output logic               ready_o,
  output logic               valid_o,
  output logic [CTRL_W-1:0]  ALUCtrl_o,
  output logic               Jr_o,
  output logic               shamt_o,
  output logic               illegal_o,
  output logic               md_start_o,
  output logic               busy_o
);

  localparam int CNT_W = $clog2(MD_CYCLES);

  state_e           r_state;
  state_e           w_next;
  logic [CNT_W-1:0] r_cnt;
  alu_dec_t         r_out;
  alu_dec_t         w_dec;
  logic             w_is_md;
  logic             w_accept;
  logic             w_md_done;
  logic             r_valid;
  logic             r_start;

  alu_ctrl_decode #(
    .OP_W    (OP_W),
    .FUNCT_W (FUNCT_W)
  ) u_dec (
    .i_op    (ALUOp_i),
    .i_funct (funct_i),
    .o_dec   (w_dec),
    .o_is_md (w_is_md)
  );

  assign ready_o = (r_state == S_IDLE)
                 & (~r_valid | ~stall_i)
                 & ~flush_i;
  assign w_accept = valid_i & ready_o;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:
        if (w_accept && w_is_md) w_next = S_MD_BUSY;
      S_MD_BUSY:
        if (r_cnt == '0) w_next = S_IDLE;
    endcase
    if (flush_i) w_next = S_IDLE;
  end

  always_comb begin
    busy_o    = (r_state == S_MD_BUSY);
    w_md_done = busy_o && (r_cnt == '0);
  end

  // MD results reuse the fields latched at accept; only valid is late.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_out   <= '0;
      r_valid <= 1'b0;
      r_start <= 1'b0;
      r_cnt   <= '0;
    end else if (flush_i) begin
      r_valid <= 1'b0;
      r_start <= 1'b0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_out   <= w_dec;
      r_valid <= ~w_is_md;
      r_start <= w_is_md;
      if (w_is_md) r_cnt <= CNT_W'(MD_CYCLES - 1);
    end else begin
      r_start <= 1'b0;
      if (w_md_done)
        r_valid <= 1'b1;
      else if (busy_o)
        r_cnt <= r_cnt - CNT_W'(1);
      else if (r_valid && !stall_i)
        r_valid <= 1'b0;
    end
  end

  assign valid_o    = r_valid;
  assign ALUCtrl_o  = CTRL_W'(r_out.code);
  assign Jr_o       = r_out.jr;
  assign shamt_o    = r_out.shamt;
  assign illegal_o  = r_out.illegal;
  assign md_start_o = r_start;

endmodule
